// File: rtl/router_pkt_gen.sv
// Packet source for router_top: header, LFSR payload and parity byte per start request,
// with every byte held while the router asserts busy.
module router_pkt_gen #(
   parameter logic [7:0]  SEED       = 8'hA5,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       addr,
   input  logic [5:0]       payload_len,
   input  logic             busy,
   output logic [7:0]       pkt_data,
   output logic             pkt_valid,
   output logic             gen_active,
   output logic             done,
   output logic             len_err,
   output logic [CNT_W-1:0] pkt_count
);

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      PAYLOAD,
      PARITY,
      GAP
   } state_t;

   // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

   state_t           state_q, state_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             active_q, active_d;
   logic             done_q, done_d;
   logic             len_err_q, len_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic [7:0]       par_q, par_d;
   logic [5:0]       len_q, len_d;
   logic [5:0]       bcnt_q, bcnt_d;
   logic [3:0]       gap_q, gap_d;
   logic [7:0]       lfsr_nx;

   // x^8+x^6+x^5+x^4+1, Fibonacci form shifting left.
   assign lfsr_nx = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         data_q    <= '0;
         valid_q   <= 1'b0;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
         len_err_q <= 1'b0;
         cnt_q     <= '0;
         lfsr_q    <= SEED;
         par_q     <= '0;
         len_q     <= '0;
         bcnt_q    <= '0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         active_q  <= active_d;
         done_q    <= done_d;
         len_err_q <= len_err_d;
         cnt_q     <= cnt_d;
         lfsr_q    <= lfsr_d;
         par_q     <= par_d;
         len_q     <= len_d;
         bcnt_q    <= bcnt_d;
         gap_q     <= gap_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      len_err_d = 1'b0;
      cnt_d     = cnt_q;
      lfsr_d    = lfsr_q;
      par_d     = par_q;
      len_d     = len_q;
      bcnt_d    = bcnt_q;
      gap_d     = gap_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (payload_len != 6'd0) begin
                  len_d   = payload_len;
                  data_d  = {payload_len, addr};
                  par_d   = {payload_len, addr};
                  valid_d = 1'b1;
                  state_d = HEADER;
               end else begin
                  len_err_d = 1'b1;
               end
            end
         end
         HEADER: begin
            if (!busy) begin
               data_d  = lfsr_q;
               par_d   = par_q ^ lfsr_q;
               lfsr_d  = lfsr_nx;
               bcnt_d  = 6'd1;
               state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (!busy) begin
               if (bcnt_q < len_q) begin
                  data_d = lfsr_q;
                  par_d  = par_q ^ lfsr_q;
                  lfsr_d = lfsr_nx;
                  bcnt_d = bcnt_q + 6'd1;
               end else begin
                  data_d  = par_q;
                  valid_d = 1'b0;
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (!busy) begin
               data_d  = '0;
               done_d  = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               gap_d   = '0;
               state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = IDLE;
            else                   gap_d   = gap_q + 4'd1;
         end
         default: state_d = IDLE;
      endcase

      active_d = (state_d != IDLE);
   end

   assign pkt_data   = data_q;
   assign pkt_valid  = valid_q;
   assign gen_active = active_q;
   assign done       = done_q;
   assign len_err    = len_err_q;
   assign pkt_count  = cnt_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Scoreboard bench for router_pkt_gen: expected bytes are queued at start and
// compared as the generator presents them to the router.
module tb_router_pkt_gen;

   localparam logic [7:0] SEED = 8'hA5;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  addr;
   logic [5:0]  payload_len;
   logic        busy;
   logic [7:0]  pkt_data;
   logic        pkt_valid;
   logic        gen_active;
   logic        done;
   logic        len_err;
   logic [15:0] pkt_count;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [8:0]  sb[$];
   logic [7:0]  m_lfsr = SEED;
   logic [15:0] exp_cnt = '0;
   bit          in_pkt = 1'b0;
   bit          done_due = 1'b0;

   router_pkt_gen #(.SEED(SEED), .GAP_CYCLES(2), .CNT_W(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .addr       (addr),
      .payload_len(payload_len),
      .busy       (busy),
      .pkt_data   (pkt_data),
      .pkt_valid  (pkt_valid),
      .gen_active (gen_active),
      .done       (done),
      .len_err    (len_err),
      .pkt_count  (pkt_count)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      logic fb;
      fb = v[7] ^ v[5] ^ v[4] ^ v[3];
      return {v[6:0], fb};
   endfunction

   task automatic push_pkt(input int len, input logic [1:0] a);
      logic [7:0] hdr, par;
      hdr = {6'(len), a};
      par = hdr;
      sb.push_back({1'b1, hdr});
      for (int i = 0; i < len; i++) begin
         sb.push_back({1'b1, m_lfsr});
         par    = par ^ m_lfsr;
         m_lfsr = lfsr_step(m_lfsr);
      end
      sb.push_back({1'b0, par});
   endtask

   // Monitor: the byte seen at negedge is the one the next rising edge accepts or holds.
   always @(negedge clock) begin
      if (reset) begin
         in_pkt   = 1'b0;
         done_due = 1'b0;
      end else begin
         if (done_due) begin
            check_val("done_pulse", done, 1);
            done_due = 1'b0;
         end else begin
            check_val("done_idle", done, 0);
         end
         if (pkt_valid || in_pkt) begin
            if (sb.size() == 0) begin
               check_val("unexpected_byte", {pkt_valid, pkt_data}, 0);
               in_pkt = 1'b0;
            end else if (busy) begin
               check_val("hold_byte", {pkt_valid, pkt_data}, sb[0]);
            end else begin
               logic [8:0] e;
               e = sb.pop_front();
               check_val("byte", {pkt_valid, pkt_data}, e);
               in_pkt = e[8];
               if (!e[8]) done_due = 1'b1;
            end
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 40 && gen_active; i++) begin
         @(posedge clock); #1;
      end
      check_val("idle_timeout", gen_active, 0);
   endtask

   // Entry/exit point: 1 time unit after a rising edge.
   task automatic send_pkt(input int len, input logic [1:0] a,
                           input int b1_idx, input int b1_n,
                           input int b2_idx, input int b2_n,
                           input bit mid_start);
      int n;
      push_pkt(len, a);
      start = 1'b1; payload_len = 6'(len); addr = a;
      @(posedge clock); #1;
      start       = mid_start;
      addr        = ~a;
      payload_len = 6'(len) ^ 6'h15;
      for (int idx = 0; idx <= len + 1; idx++) begin
         n = (idx == b1_idx) ? b1_n : (idx == b2_idx) ? b2_n : 0;
         repeat (n) begin
            busy = 1'b1;
            @(posedge clock); #1;
         end
         busy = 1'b0;
         @(posedge clock); #1;
      end
      exp_cnt++;
      check_val("post_parity_data", pkt_data, 0);
      check_val("post_parity_valid", pkt_valid, 0);
      check_val("gap_active", gen_active, 1);
      @(posedge clock); #1;
      start = 1'b0;
      wait_idle();
      check_val("pkt_count", pkt_count, exp_cnt);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; addr = '0; payload_len = '0; busy = 1'b0;
      #1;
      check_val("rst_data", pkt_data, 0);
      check_val("rst_valid", pkt_valid, 0);
      check_val("rst_active", gen_active, 0);
      check_val("rst_done", done, 0);
      check_val("rst_len_err", len_err, 0);
      check_val("rst_count", pkt_count, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;

      send_pkt(14, 2'd1, -1, 0, -1, 0, 1'b0);
      send_pkt(1, 2'd2, -1, 0, -1, 0, 1'b0);
      send_pkt(6, 2'd3, 3, 3, -1, 0, 1'b1);
      send_pkt(4, 2'd0, 0, 2, 5, 1, 1'b0);

      start = 1'b1; payload_len = 6'd0; addr = 2'd1;
      @(posedge clock); #1;
      start = 1'b0;
      check_val("len_err_pulse", len_err, 1);
      check_val("len_err_valid", pkt_valid, 0);
      check_val("len_err_active", gen_active, 0);
      @(posedge clock); #1;
      check_val("len_err_clear", len_err, 0);
      check_val("len_err_count", pkt_count, exp_cnt);

      push_pkt(16, 2'd3);
      start = 1'b1; payload_len = 6'd16; addr = 2'd3;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge clock); #1;
      end
      reset = 1'b1;
      #1;
      check_val("abort_valid", pkt_valid, 0);
      check_val("abort_count", pkt_count, 0);
      check_val("abort_active", gen_active, 0);
      sb.delete();
      m_lfsr  = SEED;
      exp_cnt = '0;
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      send_pkt(3, 2'd2, -1, 0, -1, 0, 1'b0);

      repeat (3) @(posedge clock);
      #1;
      check_val("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
